pwm_compare: RTL and testbench



---
 rtl/pwm_compare.sv | 69 ++++++
 tb/tb_pwm_compare.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// pwm_compare: registered PWM from a magnitude compare against an upstream counter, with duty updates held until a period boundary
//   clk, rst          clock and synchronous active-high reset
//   count             upstream counter value
//   enable            1 = generate PWM and count periods
//   duty_in/valid     requested duty, valid/ready handshake into a pending slot
//   duty_ready        pending slot is free
//   pwm               registered PWM output, POL selects the inactive level
//   period_start      one-cycle strobe aligned with the first pwm cycle of a period
//   period_cnt        number of period starts seen while enabled, wraps
module pwm_compare #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter bit POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_start,
  output logic [CNT_W-1:0] period_cnt
);
  logic [WIDTH-1:0] count_q, active_q, active_d, pend_q, pend_d, eff_duty;
  logic             first_q, pending_q, pending_d, pwm_q, pwm_d, ps_q, ps_d;
  logic             start_det, apply, xfer;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  assign duty_ready = !pending_q && !rst;
  always_comb begin
    // a start is entering zero, or sitting at zero on the first cycle after reset
    start_det = (count == '0) && (count_q != '0 || first_q);
    apply     = start_det && pending_q && enable;
    xfer      = duty_valid && duty_ready;
    // a duty applied at this start already governs the period's first cycle
    eff_duty  = apply ? pend_q : active_q;
    active_d  = eff_duty;
    pend_d    = xfer ? duty_in : pend_q;
    pending_d = xfer ? 1'b1 : apply ? 1'b0 : pending_q;
    pwm_d     = (enable && (count < eff_duty)) ^ POL;
    ps_d      = start_det && enable;
    pcnt_d    = pcnt_q + CNT_W'(ps_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      first_q   <= 1'b1;
      active_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      pwm_q     <= POL;
      ps_q      <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      count_q   <= count;
      first_q   <= 1'b0;
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      pcnt_q    <= pcnt_d;
    end
  end
  assign pwm          = pwm_q;
  assign period_start = ps_q;
  assign period_cnt   = pcnt_q;
endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: directed bench for pwm_compare, active-high 16-bit counter build beside an inverted 4-bit counter build
module tb_pwm_compare;
  logic        clk, rst, enable, duty_valid, hold;
  logic [7:0]  count, duty_in, last;
  logic        ready0, ready1, pwm0, pwm1, ps0, ps1;
  logic [15:0] pc0;
  logic [3:0]  pc1;
  int          errors = 0, checks = 0;

  pwm_compare #(.WIDTH(8), .CNT_W(16), .POL(1'b0)) u0 (
    .clk(clk), .rst(rst), .count(count), .enable(enable), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(ready0), .pwm(pwm0),
    .period_start(ps0), .period_cnt(pc0));
  pwm_compare #(.WIDTH(8), .CNT_W(4), .POL(1'b1)) u1 (
    .clk(clk), .rst(rst), .count(count), .enable(enable), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(ready1), .pwm(pwm1),
    .period_start(ps1), .period_cnt(pc1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    last = count;
    if (!hold) count = count + 8'd1;
  endtask

  task automatic run(input int n, output int hi0, output int hi1, output int st, output int lo_at);
    hi0 = 0; hi1 = 0; st = 0; lo_at = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm0) hi0++;
      if (!pwm1) hi1++;
      if (ps0) st++;
      if (!pwm0) lo_at = int'(last);
    end
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; duty_valid = 0; duty_in = 0; count = 0; hold = 1;
    repeat (3) step();
    checks++; if (pwm0 !== 1'b0) begin errors++; $display("FAIL reset_pwm0 got=%b exp=0", pwm0); end
    checks++; if (pwm1 !== 1'b1) begin errors++; $display("FAIL reset_pwm1 got=%b exp=1", pwm1); end
    checks++; if (ps0 !== 1'b0) begin errors++; $display("FAIL reset_ps got=%b exp=0", ps0); end
    checks++; if (pc0 !== 16'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc0); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready0); end
  endtask

  task automatic test_basic();
    int h0, h1, st, lo;
    rst = 0; enable = 1; duty_in = 8'h40; duty_valid = 1; hold = 0;
    #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL basic_ready_idle got=%b exp=1", ready0); end
    step();
    duty_valid = 0;
    checks++; if (ps0 !== 1'b1) begin errors++; $display("FAIL basic_first_start got=%b exp=1", ps0); end
    checks++; if (pc0 !== 16'd1) begin errors++; $display("FAIL basic_pc1 got=%0d exp=1", pc0); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL basic_ready_pending got=%b exp=0", ready0); end
    run(255, h0, h1, st, lo);
    checks++; if (h0 !== 0) begin errors++; $display("FAIL basic_first_period_hi got=%0d exp=0", h0); end
    run(256, h0, h1, st, lo);
    checks++; if (h0 !== 64) begin errors++; $display("FAIL basic_hi64 got=%0d exp=64", h0); end
    checks++; if (st !== 1) begin errors++; $display("FAIL basic_starts got=%0d exp=1", st); end
    checks++; if (pc0 !== 16'd2) begin errors++; $display("FAIL basic_pc2 got=%0d exp=2", pc0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL basic_ready_applied got=%b exp=1", ready0); end
  endtask

  task automatic test_midperiod_write();
    int a, b, h1, st, lo, tot;
    run(128, a, h1, st, lo);
    duty_in = 8'hC0; duty_valid = 1;
    step();
    duty_valid = 0;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL mid_ready_drop got=%b exp=0", ready0); end
    run(127, b, h1, st, lo);
    tot = a + b;
    checks++; if (tot !== 64) begin errors++; $display("FAIL mid_keep64 got=%0d exp=64", tot); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL mid_ready_held got=%b exp=0", ready0); end
    run(1, a, h1, st, lo);
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL mid_ready_back got=%b exp=1", ready0); end
    checks++; if (pwm0 !== 1'b1) begin errors++; $display("FAIL mid_first_cycle got=%b exp=1", pwm0); end
    run(255, b, h1, st, lo);
    tot = a + b;
    checks++; if (tot !== 192) begin errors++; $display("FAIL mid_hi192 got=%0d exp=192", tot); end
  endtask

  task automatic test_duty_extremes();
    int h0, h1, st, lo;
    duty_in = 8'h00; duty_valid = 1;
    step();
    duty_valid = 0;
    run(255, h0, h1, st, lo);
    run(256, h0, h1, st, lo);
    checks++; if (h0 !== 0) begin errors++; $display("FAIL d00_hi got=%0d exp=0", h0); end
    checks++; if (h1 !== 0) begin errors++; $display("FAIL d00_inv_active got=%0d exp=0", h1); end
    duty_in = 8'hFF; duty_valid = 1;
    step();
    duty_valid = 0;
    run(255, h0, h1, st, lo);
    run(256, h0, h1, st, lo);
    checks++; if (h0 !== 255) begin errors++; $display("FAIL dff_hi got=%0d exp=255", h0); end
    checks++; if (lo !== 255) begin errors++; $display("FAIL dff_low_at got=%0d exp=255", lo); end
    checks++; if (h1 !== 255) begin errors++; $display("FAIL dff_inv_active got=%0d exp=255", h1); end
  endtask

  task automatic test_loads();
    int h0, h1, st, lo;
    logic [15:0] pc_b;
    run(5, h0, h1, st, lo);
    pc_b = pc0;
    step();
    count = 8'h10;
    run(20, h0, h1, st, lo);
    checks++; if (st !== 0) begin errors++; $display("FAIL load10_starts got=%0d exp=0", st); end
    run(12, h0, h1, st, lo);
    step();
    count = 8'h00;
    run(32, h0, h1, st, lo);
    checks++; if (st !== 1) begin errors++; $display("FAIL load00_starts got=%0d exp=1", st); end
    count = 8'h00; hold = 1;
    run(5, h0, h1, st, lo);
    hold = 0;
    checks++; if (st !== 1) begin errors++; $display("FAIL hold00_starts got=%0d exp=1", st); end
    checks++; if (pc0 !== pc_b + 16'd2) begin errors++; $display("FAIL load_pc got=%0d exp=%0d", pc0, pc_b + 16'd2); end
  endtask

  task automatic test_disable();
    int h0, h1, st, lo;
    logic [15:0] pc_b;
    pc_b = pc0;
    enable = 0; duty_in = 8'h20; duty_valid = 1;
    #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL dis_ready_before got=%b exp=1", ready0); end
    step();
    duty_valid = 0;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL dis_ready_after got=%b exp=0", ready0); end
    run(599, h0, h1, st, lo);
    checks++; if (h0 !== 0 || h1 !== 0) begin errors++; $display("FAIL dis_pwm_active got=%0d/%0d exp=0/0", h0, h1); end
    checks++; if (st !== 0) begin errors++; $display("FAIL dis_starts got=%0d exp=0", st); end
    checks++; if (pc0 !== pc_b) begin errors++; $display("FAIL dis_pc_frozen got=%0d exp=%0d", pc0, pc_b); end
    enable = 1;
    run(168, h0, h1, st, lo);
    run(256, h0, h1, st, lo);
    checks++; if (h0 !== 32 || h1 !== 32) begin errors++; $display("FAIL dis_applied_hi got=%0d/%0d exp=32/32", h0, h1); end
    checks++; if (pc0 !== pc_b + 16'd1) begin errors++; $display("FAIL dis_pc_resume got=%0d exp=%0d", pc0, pc_b + 16'd1); end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [15:0] pc_b;
    pc_b = pc0;
    hold = 1;
    for (int i = 0; i < 40 && pc1 != 4'hF; i++) begin
      count = 8'h00; step();
      count = 8'h01; step();
      n++;
    end
    checks++; if (pc1 !== 4'hF) begin errors++; $display("FAIL wrap_reach15 got=%0d exp=15", pc1); end
    count = 8'h00; step();
    checks++; if (pc1 !== 4'h0) begin errors++; $display("FAIL wrap_to0 got=%0d exp=0", pc1); end
    checks++; if (pc0 !== pc_b + 16'(n) + 16'd1) begin errors++; $display("FAIL wrap_pc0 got=%0d exp=%0d", pc0, pc_b + 16'(n) + 16'd1); end
  endtask

  task automatic test_reset_mid();
    int h0, h1, st, lo;
    hold = 0; count = 8'h37;
    run(3, h0, h1, st, lo);
    rst = 1; hold = 1;
    step();
    checks++; if (pwm0 !== 1'b0 || pwm1 !== 1'b1) begin errors++; $display("FAIL rmid_pwm got=%b%b exp=01", pwm0, pwm1); end
    checks++; if (ps0 !== 1'b0 || pc0 !== 16'd0 || pc1 !== 4'd0) begin errors++; $display("FAIL rmid_cnt got=%b/%0d/%0d exp=0/0/0", ps0, pc0, pc1); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%b exp=0", ready0); end
    rst = 0; count = 8'h00;
    #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rmid_ready_rel got=%b exp=1", ready0); end
    step();
    checks++; if (ps0 !== 1'b1 || pc0 !== 16'd1) begin errors++; $display("FAIL rmid_first_start got=%b/%0d exp=1/1", ps0, pc0); end
    checks++; if (pwm0 !== 1'b0 || pwm1 !== 1'b1) begin errors++; $display("FAIL rmid_idle_pwm got=%b%b exp=01", pwm0, pwm1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midperiod_write();
    test_duty_extremes();
    test_loads();
    test_disable();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
